imm_decode_pipe: RTL



---
 rtl/imm_decode_pipe_pkg.sv | 50 +++++
 rtl/imm_decode_pipe_if.sv | 30 +++
 rtl/imm_decode_pipe_field_decode.sv | 44 ++++
 rtl/imm_decode_pipe.sv | 99 +++++++++
 4 files changed

// File: rtl/imm_decode_pipe_pkg.sv
// Shared opcodes, format codes and the decoded-field record for the RV32I
// immediate/field decode pipeline.
package imm_decode_pkg;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_R       = 3'd0,
        FMT_I       = 3'd1,
        FMT_S       = 3'd2,
        FMT_B       = 3'd3,
        FMT_U       = 3'd4,
        FMT_J       = 3'd5,
        FMT_ILLEGAL = 3'd7
    } fmt_e;

    typedef struct packed {
        fmt_e       fmt;
        logic       illegal;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [6:0] funct7;
    } dec_result_t;

    // Anything outside the base opcode map, including compressed encodings
    // (instr[1:0] != 2'b11), falls through to ILLEGAL.
    function automatic fmt_e fmt_of(input logic [6:0] opcode);
        case (opcode)
            OP_REG:                               return FMT_R;
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:  return FMT_I;
            OP_STORE:                             return FMT_S;
            OP_BRANCH:                            return FMT_B;
            OP_LUI, OP_AUIPC:                     return FMT_U;
            OP_JAL:                               return FMT_J;
            default:                              return FMT_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/imm_decode_pipe_if.sv
// Handshake bus of the decode pipeline: instruction in, decoded fields out.
interface imm_decode_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [2:0]      out_fmt;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [XLEN-1:0] out_imm;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_fmt, out_rs1, out_rs2, out_rd,
               out_funct3, out_funct7, out_imm, out_illegal
    );

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_fmt, out_rs1, out_rs2, out_rd,
               out_funct3, out_funct7, out_imm, out_illegal
    );
endinterface

// File: rtl/imm_decode_pipe_field_decode.sv
// Combinational RV32I field splitter and immediate generator.
module imm_field_decode
    import imm_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output dec_result_t     res,
    output logic [XLEN-1:0] imm
);

    logic signed [31:0]   imm_raw;
    logic signed [XLEN-1:0] imm_x;

    always_comb begin
        res         = '0;
        res.fmt     = fmt_of(instr[6:0]);
        res.illegal = (res.fmt == FMT_ILLEGAL);
        res.rs1     = instr[19:15];
        res.rs2     = instr[24:20];
        res.rd      = instr[11:7];
        res.funct3  = instr[14:12];
        res.funct7  = instr[31:25];
    end

    // Each format is sign-extended to 32 bits here, then widened to XLEN.
    always_comb begin
        imm_raw = '0;
        case (res.fmt)
            FMT_I: imm_raw = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm_raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm_raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                              instr[11:8], 1'b0};
            FMT_U: imm_raw = {instr[31:12], 12'b0};
            FMT_J: imm_raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                              instr[30:21], 1'b0};
            default: imm_raw = '0;
        endcase
    end

    assign imm_x = XLEN'(imm_raw);
    assign imm   = imm_x;

endmodule

// File: rtl/imm_decode_pipe.sv
// Registered instruction decoder with a two-entry skid buffer and a count of
// results consumed downstream.
module imm_decode_pipe
    import imm_decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    imm_decode_pipe_if.slave bus,
    output logic [CNT_W-1:0] dec_count
);

    typedef struct packed {
        dec_result_t     f;
        logic [XLEN-1:0] imm;
    } entry_t;

    dec_result_t     res_p0;
    logic [XLEN-1:0] imm_p0;
    entry_t          entry_p0;

    entry_t           main_p1;
    entry_t           skid_p1;
    logic             vld_p1;
    logic             skid_vld_p1;
    logic             rdy_p1;
    logic [CNT_W-1:0] count_p1;

    logic accept;
    logic drain;
    logic skid_vld_nxt;

    // Stage 0: combinational decode of the presented word
    imm_field_decode #(.XLEN(XLEN)) u_decode (
        .instr (bus.in_instr),
        .res   (res_p0),
        .imm   (imm_p0)
    );

    assign entry_p0 = '{f: res_p0, imm: imm_p0};

    assign accept = bus.in_valid && rdy_p1;
    assign drain  = vld_p1 && bus.out_ready;

    // Ready is only low while skid holds a result, so accept and a full skid
    // never coincide.
    always_comb begin
        skid_vld_nxt = skid_vld_p1;
        if (drain && skid_vld_p1)
            skid_vld_nxt = 1'b0;
        else if (!drain && accept && vld_p1)
            skid_vld_nxt = 1'b1;
    end

    // Stage 1: main/skid registers, ready and drain counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_p1     <= '0;
            skid_p1     <= '0;
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
            rdy_p1      <= 1'b1;
            count_p1    <= '0;
        end else begin
            skid_vld_p1 <= skid_vld_nxt;
            rdy_p1      <= !skid_vld_nxt;
            if (drain) begin
                count_p1 <= count_p1 + CNT_W'(1);
                if (skid_vld_p1)
                    main_p1 <= skid_p1;
                else if (accept)
                    main_p1 <= entry_p0;
                vld_p1 <= skid_vld_p1 || accept;
            end else if (accept) begin
                if (vld_p1) begin
                    skid_p1 <= entry_p0;
                end else begin
                    main_p1 <= entry_p0;
                    vld_p1  <= 1'b1;
                end
            end
        end
    end

    assign bus.in_ready    = rdy_p1;
    assign bus.out_valid   = vld_p1;
    assign bus.out_fmt     = main_p1.f.fmt;
    assign bus.out_illegal = main_p1.f.illegal;
    assign bus.out_rs1     = main_p1.f.rs1;
    assign bus.out_rs2     = main_p1.f.rs2;
    assign bus.out_rd      = main_p1.f.rd;
    assign bus.out_funct3  = main_p1.f.funct3;
    assign bus.out_funct7  = main_p1.f.funct7;
    assign bus.out_imm     = main_p1.imm;
    assign dec_count       = count_p1;

endmodule
